// File: rtl/bulk_endp_pkt_if.sv
// bulk_endp_pkt_if: application-side and SIE-side signals of the bulk endpoint pair
interface bulk_endp_pkt_if #(
    parameter int IN_DEPTH  = 16,
    parameter int OUT_DEPTH = 16
);
    localparam int LWI = $clog2(IN_DEPTH) + 1;
    localparam int LWO = $clog2(OUT_DEPTH) + 1;
    logic [7:0]     app_in_data;
    logic           app_in_valid;
    logic           app_in_ready;
    logic [LWI-1:0] app_in_level;
    logic [7:0]     app_out_data;
    logic           app_out_valid;
    logic           app_out_ready;
    logic [LWO-1:0] app_out_level;
    logic [7:0]     in_data;
    logic           in_valid;
    logic           in_req;
    logic           in_ready;
    logic           out_nak;
    logic [7:0]     out_data;
    logic           out_valid;
    logic           out_err;
    logic           out_ready;
    modport slave (
        input  app_in_data, app_in_valid, app_out_ready, in_req, in_ready,
               out_data, out_valid, out_err, out_ready,
        output app_in_ready, app_in_level, app_out_data, app_out_valid, app_out_level,
               in_data, in_valid, out_nak
    );
    modport master (
        output app_in_data, app_in_valid, app_out_ready, in_req, in_ready,
               out_data, out_valid, out_err, out_ready,
        input  app_in_ready, app_in_level, app_out_data, app_out_valid, app_out_level,
               in_data, in_valid, out_nak
    );
endinterface

// File: rtl/bulk_endp_pkt.sv
// bulk_endp_pkt: full-speed bulk IN/OUT endpoint pair with packet commit, IN replay and OUT rollback
module bulk_endp_pkt #(
    parameter int IN_MPS    = 8,
    parameter int OUT_MPS   = 8,
    parameter int IN_DEPTH  = 16,
    parameter int OUT_DEPTH = 16
) (
    input logic            clk_i,
    input logic            rstn_i,
    bulk_endp_pkt_if.slave bus
);
    localparam int LWI = $clog2(IN_DEPTH) + 1;
    localparam int LWO = $clog2(OUT_DEPTH) + 1;
    localparam int AWI = LWI - 1;
    localparam int AWO = LWO - 1;
    localparam logic [6:0] IMPS = 7'(IN_MPS);
    localparam logic [6:0] OMPS = 7'(OUT_MPS);
    localparam logic [LWI-1:0] IDEP = LWI'(IN_DEPTH);
    localparam logic [LWO-1:0] ODEP = LWO'(OUT_DEPTH);
    typedef enum logic [1:0] {I_IDLE, I_SEND, I_ACKD} in_state_t;
    typedef enum logic [1:0] {O_IDLE, O_DATA, O_NAK} out_state_t;
    logic [7:0] in_mem [IN_DEPTH];
    logic [7:0] out_mem [OUT_DEPTH];
    in_state_t in_st, in_st_n;
    out_state_t out_st, out_st_n;
    logic [LWI-1:0] wr, wr_n, rd_c, rd_c_n, rd_t, rd_t_n, in_lvl, in_used;
    logic [LWO-1:0] wr_c, wr_c_n, wr_t, wr_t_n, rd, rd_n, out_lvl, free, o_addr;
    logic [6:0] sent, sent_n, avail, avail_n, cnt, cnt_n;
    logic req_q, in_valid_q, in_valid_n, nak, nak_n;
    logic in_rdy, in_push, out_vld, out_pop, o_byte, o_end, o_store;
    assign in_used           = wr - rd_c;
    assign in_rdy            = in_used != IDEP;
    assign in_push           = bus.app_in_valid && in_rdy;
    assign out_vld           = wr_c != rd;
    assign out_pop           = out_vld && bus.app_out_ready;
    assign free              = ODEP - (wr_c - rd);
    assign o_byte            = bus.out_ready && bus.out_valid && !bus.out_err;
    assign o_end             = bus.out_ready && !bus.out_valid && !bus.out_err;
    assign bus.app_in_ready  = in_rdy;
    assign bus.app_in_level  = in_lvl;
    assign bus.in_valid      = in_valid_q;
    assign bus.in_data       = in_valid_q ? in_mem[rd_t[AWI-1:0]] : 8'h00;
    assign bus.app_out_valid = out_vld;
    assign bus.app_out_data  = out_vld ? out_mem[rd[AWO-1:0]] : 8'h00;
    assign bus.app_out_level = out_lvl;
    assign bus.out_nak       = nak;
    // IN side: snapshot a packet on request, stream it tentatively, commit only after ACK
    always_comb begin
        in_st_n = in_st;
        rd_c_n  = rd_c;
        rd_t_n  = rd_t;
        sent_n  = sent;
        avail_n = avail;
        wr_n    = wr + LWI'(in_push);
        case (in_st)
            I_IDLE: if (bus.in_req && !req_q) begin
                in_st_n = I_SEND;
                rd_t_n  = rd_c;
                sent_n  = 7'd0;
                avail_n = (32'(in_used) > IN_MPS) ? IMPS : 7'(in_used);
            end
            I_SEND: if (!bus.in_req) in_st_n = I_IDLE;
                else if (o_end) in_st_n = I_ACKD;
                else if (bus.in_ready && in_valid_q) begin
                    rd_t_n = rd_t + LWI'(1);
                    sent_n = sent + 7'd1;
                end
            I_ACKD: if (!bus.in_req) begin
                rd_c_n  = rd_t;
                in_st_n = I_IDLE;
            end
            default: in_st_n = I_IDLE;
        endcase
        in_valid_n = (in_st_n == I_SEND) && (sent_n < avail_n);
    end
    // OUT side: accept a packet tentatively, commit on end, drop on error or babble
    always_comb begin
        out_st_n = out_st;
        wr_c_n   = wr_c;
        wr_t_n   = wr_t;
        cnt_n    = cnt;
        nak_n    = nak;
        o_store  = 1'b0;
        o_addr   = wr_t;
        rd_n     = rd + LWO'(out_pop);
        if (bus.out_ready && bus.out_err) begin
            out_st_n = O_IDLE;
            nak_n    = 1'b0;
        end else case (out_st)
            O_IDLE: if (o_byte) begin
                if (32'(free) >= OUT_MPS) begin
                    o_store  = 1'b1;
                    o_addr   = wr_c;
                    wr_t_n   = wr_c + LWO'(1);
                    cnt_n    = 7'd1;
                    nak_n    = 1'b0;
                    out_st_n = O_DATA;
                end else begin
                    nak_n    = 1'b1;
                    out_st_n = O_NAK;
                end
            end
            O_DATA: if (o_byte) begin
                if (cnt < OMPS) begin
                    o_store = 1'b1;
                    wr_t_n  = wr_t + LWO'(1);
                    cnt_n   = cnt + 7'd1;
                end else begin
                    nak_n    = 1'b0;
                    out_st_n = O_NAK;
                end
            end else if (o_end) begin
                wr_c_n   = wr_t;
                out_st_n = O_IDLE;
            end
            O_NAK: if (o_end) out_st_n = O_IDLE;
            default: out_st_n = O_IDLE;
        endcase
    end
    // state, pointer and level registers; levels track the committed pointers
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            in_st      <= I_IDLE;
            out_st     <= O_IDLE;
            wr         <= '0;
            rd_c       <= '0;
            rd_t       <= '0;
            sent       <= '0;
            avail      <= '0;
            req_q      <= 1'b0;
            in_valid_q <= 1'b0;
            in_lvl     <= '0;
            wr_c       <= '0;
            wr_t       <= '0;
            rd         <= '0;
            cnt        <= '0;
            nak        <= 1'b0;
            out_lvl    <= '0;
        end else begin
            in_st      <= in_st_n;
            out_st     <= out_st_n;
            wr         <= wr_n;
            rd_c       <= rd_c_n;
            rd_t       <= rd_t_n;
            sent       <= sent_n;
            avail      <= avail_n;
            req_q      <= bus.in_req;
            in_valid_q <= in_valid_n;
            in_lvl     <= wr_n - rd_c_n;
            wr_c       <= wr_c_n;
            wr_t       <= wr_t_n;
            rd         <= rd_n;
            cnt        <= cnt_n;
            nak        <= nak_n;
            out_lvl    <= wr_c_n - rd_n;
        end
    end
    // byte storage for both FIFOs
    always_ff @(posedge clk_i) begin
        if (in_push) in_mem[wr[AWI-1:0]] <= bus.app_in_data;
        if (o_store) out_mem[o_addr[AWO-1:0]] <= bus.out_data;
    end
endmodule

// File: tb/tb_bulk_endp_pkt.sv
// tb_bulk_endp_pkt: directed stimulus with queue scoreboards for IN and OUT byte streams
module tb_bulk_endp_pkt;
    logic clk_i = 1'b0;
    logic rstn_i = 1'b0;
    int compared = 0;
    int failed = 0;
    logic [7:0] in_q[$];
    logic [7:0] out_q[$];
    bulk_endp_pkt_if #(.IN_DEPTH(16), .OUT_DEPTH(16)) bus();
    bulk_endp_pkt #(.IN_MPS(8), .OUT_MPS(8), .IN_DEPTH(16), .OUT_DEPTH(16)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .bus(bus.slave));
    always #5 clk_i = ~clk_i;
    task automatic chk(string name, int act, int exp);
        compared++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask
    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask
    // monitor: pop the expected byte whenever a byte is handed over on either side
    always @(negedge clk_i) begin
        if (rstn_i && bus.in_valid && bus.in_ready) begin
            if (in_q.size() == 0) chk("in_data_unexpected", bus.in_data, -1);
            else chk("in_data", bus.in_data, in_q.pop_front());
        end
        if (rstn_i && bus.app_out_valid && bus.app_out_ready) begin
            if (out_q.size() == 0) chk("out_data_unexpected", bus.app_out_data, -1);
            else chk("app_out_data", bus.app_out_data, out_q.pop_front());
        end
    end
    task automatic check_reset;
        chk("rst_app_in_ready", bus.app_in_ready, 1);
        chk("rst_app_in_level", bus.app_in_level, 0);
        chk("rst_app_out_valid", bus.app_out_valid, 0);
        chk("rst_app_out_level", bus.app_out_level, 0);
        chk("rst_app_out_data", bus.app_out_data, 0);
        chk("rst_in_valid", bus.in_valid, 0);
        chk("rst_in_data", bus.in_data, 0);
        chk("rst_out_nak", bus.out_nak, 0);
    endtask
    task automatic app_write(int n, int base);
        for (int i = 0; i < n; i++) begin
            chk("app_in_ready", bus.app_in_ready, 1);
            bus.app_in_data = 8'(base + i);
            bus.app_in_valid = 1'b1;
            tick;
            bus.app_in_valid = 1'b0;
        end
    endtask
    task automatic in_packet(int n, int base, bit ack);
        for (int i = 0; i < n; i++) in_q.push_back(8'(base + i));
        bus.in_req = 1'b1;
        tick;
        for (int i = 0; i < n; i++) begin
            chk("in_valid", bus.in_valid, 1);
            bus.in_ready = 1'b1;
            tick;
            bus.in_ready = 1'b0;
        end
        chk("in_pkt_end", bus.in_valid, 0);
        if (ack) begin
            bus.out_ready = 1'b1;
            tick;
            bus.out_ready = 1'b0;
        end
        bus.in_req = 1'b0;
        tick;
    endtask
    task automatic out_tok(bit v, bit e, logic [7:0] d);
        bus.out_data = d;
        bus.out_valid = v;
        bus.out_err = e;
        bus.out_ready = 1'b1;
        tick;
        bus.out_ready = 1'b0;
        bus.out_valid = 1'b0;
        bus.out_err = 1'b0;
    endtask
    task automatic out_packet(int n, int base, bit fin);
        for (int i = 0; i < n; i++) out_tok(1'b1, 1'b0, 8'(base + i));
        if (fin) out_tok(1'b0, 1'b0, 8'h00);
    endtask
    task automatic app_drain(int n);
        bus.app_out_ready = 1'b1;
        repeat (n) tick;
        bus.app_out_ready = 1'b0;
    endtask
    initial begin
        bus.app_in_data = 8'h00;
        bus.app_in_valid = 1'b0;
        bus.app_out_ready = 1'b0;
        bus.in_req = 1'b0;
        bus.in_ready = 1'b0;
        bus.out_data = 8'h00;
        bus.out_valid = 1'b0;
        bus.out_err = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) tick;
        check_reset;
        rstn_i = 1'b1;
        tick;
        app_write(5, 0);
        chk("in_level_5", bus.app_in_level, 5);
        in_packet(5, 0, 1'b1);
        chk("in_level_0", bus.app_in_level, 0);
        app_write(16, 10);
        chk("in_full_ready", bus.app_in_ready, 0);
        chk("in_level_16", bus.app_in_level, 16);
        in_packet(8, 10, 1'b1);
        chk("in_ready_after_ack", bus.app_in_ready, 1);
        chk("in_level_8", bus.app_in_level, 8);
        app_write(4, 26);
        chk("in_level_12", bus.app_in_level, 12);
        in_packet(8, 18, 1'b1);
        in_packet(4, 26, 1'b1);
        chk("in_level_after_3pkt", bus.app_in_level, 0);
        in_packet(0, 0, 1'b1);
        app_write(8, 40);
        in_packet(8, 40, 1'b0);
        chk("in_level_no_ack", bus.app_in_level, 8);
        in_packet(8, 40, 1'b1);
        chk("in_level_replayed", bus.app_in_level, 0);
        out_packet(8, 8'h80, 1'b1);
        chk("out_level_8", bus.app_out_level, 8);
        chk("out_valid", bus.app_out_valid, 1);
        for (int i = 0; i < 8; i++) out_q.push_back(8'(8'h80 + i));
        app_drain(8);
        chk("out_level_drained", bus.app_out_level, 0);
        out_packet(3, 8'h70, 1'b0);
        out_tok(1'b0, 1'b1, 8'h00);
        chk("out_level_err", bus.app_out_level, 0);
        chk("out_valid_err", bus.app_out_valid, 0);
        out_packet(9, 8'h60, 1'b1);
        chk("out_level_babble", bus.app_out_level, 0);
        chk("out_nak_babble", bus.out_nak, 0);
        out_packet(8, 8'h90, 1'b1);
        out_packet(2, 8'hA0, 1'b1);
        chk("out_level_10", bus.app_out_level, 10);
        out_tok(1'b1, 1'b0, 8'hB0);
        chk("out_nak_set", bus.out_nak, 1);
        out_packet(3, 8'hB1, 1'b1);
        chk("out_nak_held", bus.out_nak, 1);
        chk("out_level_nak", bus.app_out_level, 10);
        out_q.push_back(8'h90);
        out_q.push_back(8'h91);
        app_drain(2);
        chk("out_level_8b", bus.app_out_level, 8);
        out_tok(1'b1, 1'b0, 8'hC0);
        chk("out_nak_clear", bus.out_nak, 0);
        out_packet(7, 8'hC1, 1'b1);
        chk("out_level_16", bus.app_out_level, 16);
        for (int i = 2; i < 8; i++) out_q.push_back(8'(8'h90 + i));
        out_q.push_back(8'hA0);
        out_q.push_back(8'hA1);
        for (int i = 0; i < 8; i++) out_q.push_back(8'(8'hC0 + i));
        app_drain(16);
        chk("out_level_final", bus.app_out_level, 0);
        out_packet(4, 8'hD0, 1'b1);
        out_packet(2, 8'hD4, 1'b0);
        app_write(3, 8'h30);
        bus.in_req = 1'b1;
        tick;
        chk("mid_in_valid", bus.in_valid, 1);
        chk("mid_out_level", bus.app_out_level, 4);
        rstn_i = 1'b0;
        #1;
        check_reset;
        bus.in_req = 1'b0;
        tick;
        rstn_i = 1'b1;
        tick;
        app_write(1, 8'h55);
        in_packet(1, 8'h55, 1'b1);
        chk("post_reset_level", bus.app_in_level, 0);
        tick;
        chk("sb_in_empty", in_q.size(), 0);
        chk("sb_out_empty", out_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end
endmodule
